mux_arb_2t1_64: RTL and testbench

//  Two-requester burst arbiter owning the shared 64-bit 2:1 mux datapath.

---
 rtl/mux_arb_2t1_64.sv | 133 +++++++++++++
 tb/tb_mux_arb_2t1_64.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_2t1_64.sv
// mux_arb_2t1_64: round-robin, burst-locked arbiter for two 64-bit producers.
// It drives the shared 2:1 mux select and registers the selected word into a
// one-entry output stage with a valid/ready handshake.
module mux_arb_2t1_64 #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [63:0] a_data,
  input  logic        a_last,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [63:0] b_data,
  input  logic        b_last,
  output logic        b_ready,
  output logic        mux_sel,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic        out_src,
  input  logic        out_ready,
  output logic        forced_rel
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  // A MAX_BURST of 0 disables forced release; the counter then simply wraps.
  localparam bit                 LIMITED   = (MAX_BURST != 0);
  localparam int unsigned        BURST_LIM = LIMITED ? MAX_BURST : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BURST_LIM - 1);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;       // 0: A wins a tie, 1: B wins a tie
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [63:0]       out_data_q, out_data_d;
  logic              out_src_q, out_src_d;
  logic              forced_q, forced_d;

  logic              own_valid;
  logic              own_last;
  logic              slot_free;
  logic              beat;
  logic [63:0]       mux_data;

  // Shared mux and handshake: only the owner sees ready, gated by output-slot space.
  always_comb begin
    mux_sel   = (state_q == OWN_B);
    mux_data  = mux_sel ? b_data  : a_data;
    own_valid = mux_sel ? b_valid : a_valid;
    own_last  = mux_sel ? b_last  : a_last;
    slot_free = ~out_valid_q | out_ready;
    a_ready   = (state_q == OWN_A) & slot_free;
    b_ready   = (state_q == OWN_B) & slot_free;
    beat      = (state_q != IDLE) & own_valid & slot_free;
  end

  // Arbitration, burst tracking and output-stage next state.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    forced_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    case (state_q)
      IDLE: begin
        if (a_valid && b_valid) state_d = prio_q ? OWN_B : OWN_A;
        else if (a_valid)       state_d = OWN_A;
        else if (b_valid)       state_d = OWN_B;
      end
      OWN_A, OWN_B: begin
        if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          // A last beat releases normally and takes precedence over the limit.
          if (own_last) begin
            state_d = IDLE;
            cnt_d   = '0;
            prio_d  = ~mux_sel;
          end else if (LIMITED && (cnt_q == CNT_LAST)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            prio_d   = ~mux_sel;
            forced_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (beat) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_src_d   = mux_sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      forced_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      forced_q    <= forced_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign forced_rel = forced_q;

endmodule

// File: tb/tb_mux_arb_2t1_64.sv
// Testbench for mux_arb_2t1_64: queue-based producers, a transaction-level
// reference of the arbiter and output slot, directed scenarios plus random traffic.
module tb_mux_arb_2t1_64;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [63:0] a_data = '0, b_data = '0;
  logic        a_last = 1'b0, b_last = 1'b0;
  logic        a_ready, b_ready, mux_sel, out_valid, out_src, forced_rel;
  logic [63:0] out_data;
  logic        out_ready = 1'b0;

  mux_arb_2t1_64 #(.MAX_BURST(MAXB), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .mux_sel(mux_sel), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready), .forced_rel(forced_rel)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic l; } beat_t;
  typedef struct { logic [63:0] d; logic s; } word_t;

  beat_t qa[$], qb[$];      // pending producer beats
  word_t oq[$];             // words held in the output slot (0 or 1)

  // Reference: who owns the bus (0 none, 1 A, 2 B), beats in current grant,
  // who wins the next tie, pending forced pulse, what the output shows.
  int          m_owner, m_beats;
  bit          m_tie_b, m_forced;
  logic [63:0] m_show_d;
  bit          m_show_s;

  int n_cmp = 0, n_bad = 0;
  int p_va = 100, p_vb = 100, p_rdy = 100;
  int ovr_a = -1, ovr_rdy = -1;
  int n_pulse = 0, n_sel_b = 0;
  int seq_a = 0, seq_b = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    oq.delete();
    m_owner = 0; m_beats = 0; m_tie_b = 0; m_forced = 0;
    m_show_d = '0; m_show_s = 0;
  endtask

  task automatic push_burst(input bit src, input int len, input int last_at);
    beat_t b;
    for (int i = 1; i <= len; i++) begin
      if (src) begin b.d = {8'hB0, 24'h0, 32'(seq_b)}; seq_b++; end
      else     begin b.d = {8'hA0, 24'h0, 32'(seq_a)}; seq_a++; end
      b.l = (i == last_at);
      if (src) qb.push_back(b); else qa.push_back(b);
    end
  endtask

  task automatic drive();
    bit en_a, en_b;
    en_a = (ovr_a >= 0) ? (ovr_a != 0) : ($urandom_range(99) < p_va);
    en_b = ($urandom_range(99) < p_vb);
    a_valid = (qa.size() > 0) && en_a;
    a_data  = (qa.size() > 0) ? qa[0].d : '0;
    a_last  = (qa.size() > 0) ? qa[0].l : 1'b0;
    b_valid = (qb.size() > 0) && en_b;
    b_data  = (qb.size() > 0) ? qb[0].d : '0;
    b_last  = (qb.size() > 0) ? qb[0].l : 1'b0;
    out_ready = (ovr_rdy >= 0) ? (ovr_rdy != 0) : ($urandom_range(99) < p_rdy);
  endtask

  task automatic check_outs();
    bit room;
    room = (oq.size() == 0) || out_ready;
    check_eq("a_ready",    a_ready,    (m_owner == 1) && room);
    check_eq("b_ready",    b_ready,    (m_owner == 2) && room);
    check_eq("mux_sel",    mux_sel,    m_owner == 2);
    check_eq("out_valid",  out_valid,  oq.size() != 0);
    check_eq("out_data",   out_data,   m_show_d);
    check_eq("out_src",    out_src,    m_show_s);
    check_eq("forced_rel", forced_rel, m_forced);
    if (forced_rel) n_pulse++;
    if (mux_sel) n_sel_b++;
  endtask

  // Advance the reference across one rising edge using the values driven this cycle.
  task automatic model_edge();
    bit room, acc, lst;
    word_t w;
    room = (oq.size() == 0) || out_ready;
    acc = 0; lst = 0;
    m_forced = 0;
    if (m_owner == 1 && a_valid && room) begin
      acc = 1; lst = a_last; w.d = a_data; w.s = 0; void'(qa.pop_front());
    end else if (m_owner == 2 && b_valid && room) begin
      acc = 1; lst = b_last; w.d = b_data; w.s = 1; void'(qb.pop_front());
    end
    if (m_owner == 0) begin
      if (a_valid && b_valid) m_owner = m_tie_b ? 2 : 1;
      else if (a_valid)       m_owner = 1;
      else if (b_valid)       m_owner = 2;
    end else if (acc) begin
      m_beats++;
      if (lst || m_beats == MAXB) begin
        m_forced = !lst;
        m_tie_b  = (m_owner == 1);
        m_owner  = 0;
        m_beats  = 0;
      end
    end
    if (out_ready && oq.size() != 0) void'(oq.pop_front());
    if (acc) begin
      oq.push_back(w);
      m_show_d = w.d; m_show_s = w.s;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    check_outs();
    @(posedge clk);
    model_edge();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Async reset asserted mid-cycle; outputs must go to reset values at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst a_ready",    a_ready,    0);
    check_eq("rst b_ready",    b_ready,    0);
    check_eq("rst mux_sel",    mux_sel,    0);
    check_eq("rst out_valid",  out_valid,  0);
    check_eq("rst out_data",   out_data,   0);
    check_eq("rst out_src",    out_src,    0);
    check_eq("rst forced_rel", forced_rel, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single source: A sends 1,2,3(last) with the consumer always ready.
    qa.push_back('{64'h1, 1'b0});
    qa.push_back('{64'h2, 1'b0});
    qa.push_back('{64'h3, 1'b1});
    run(8);
    check_eq("single last word", out_data, 64'h3);

    // Contention from reset with one-beat bursts: grants alternate A,B,A,B.
    do_reset();
    qa.delete(); qb.delete();
    for (int i = 0; i < 4; i++) begin push_burst(0, 1, 1); push_burst(1, 1, 1); end
    run(20);
    check_eq("contention drained", qa.size() + qb.size(), 0);

    // Backpressure while B owns: consumer stalls for five cycles.
    do_reset();
    push_burst(1, 3, 3);
    run(2);
    ovr_rdy = 0;
    run(5);
    ovr_rdy = -1;
    run(6);
    check_eq("backpressure drained", qb.size(), 0);

    // Forced release after four A beats with B waiting, then last on beat four.
    do_reset();
    n_pulse = 0;
    push_burst(0, 6, 6);
    push_burst(1, 1, 1);
    run(16);
    check_eq("forced pulses", n_pulse, 1);
    n_pulse = 0;
    push_burst(0, 4, 4);
    run(8);
    check_eq("last on limit pulses", n_pulse, 0);

    // Bubble: A owns, drops valid for three cycles while B requests.
    do_reset();
    push_burst(0, 5, 5);
    push_burst(1, 2, 2);
    ovr_a = 1;
    run(3);
    n_sel_b = 0;
    ovr_a = 0;
    run(3);
    check_eq("bubble no steal", n_sel_b, 0);
    ovr_a = 1;
    run(6);
    ovr_a = -1;
    run(8);

    // Random traffic with a reset dropped in mid-stream.
    p_va = 70; p_vb = 70; p_rdy = 75;
    for (int i = 0; i < 3000; i++) begin
      if (qa.size() == 0 && $urandom_range(3) == 0) push_burst(0, $urandom_range(1, 7), 0);
      if (qa.size() != 0 && qa[qa.size()-1].l == 1'b0 && $urandom_range(2) == 0)
        qa[qa.size()-1].l = 1'b1;
      if (qb.size() == 0 && $urandom_range(3) == 0) push_burst(1, $urandom_range(1, 7), $urandom_range(1, 7));
      if (i == 1500) do_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
